// File: rtl/arm_decode_pkg.sv
// arm_decode_pkg
// Shared definitions for the instruction front end of the microsequencer:
//   FETCH_STATE   - microstate address of FETCH (family 13 slot, 13 x 8)
//   FAM_*         - the 16 instruction family indices (bit positions of family_bits)
//   cond_e        - ARM condition-code field encoding (ir[31:28])
//   FLAG_*        - bit positions of N, Z, C, V inside the 4-bit flags vector
//   fetch_state_e - states of the front-end fetch FSM
//   familyOneHot  - converts a family index into its one-hot family_bits value
package arm_decode_pkg;

  // Family indices; each one also names a bit of the one-hot family_bits vector
  localparam logic [3:0] FAM_DP_IMM_SHIFT = 4'd0;
  localparam logic [3:0] FAM_DP_REG_SHIFT = 4'd1;
  localparam logic [3:0] FAM_DP_IMM       = 4'd2;
  localparam logic [3:0] FAM_MUL          = 4'd3;
  localparam logic [3:0] FAM_MUL_LONG     = 4'd4;
  localparam logic [3:0] FAM_SWP          = 4'd5;
  localparam logic [3:0] FAM_HALFWORD     = 4'd6;
  localparam logic [3:0] FAM_LS_IMM       = 4'd7;
  localparam logic [3:0] FAM_LS_REG       = 4'd8;
  localparam logic [3:0] FAM_BLOCK        = 4'd9;
  localparam logic [3:0] FAM_BRANCH       = 4'd10;
  localparam logic [3:0] FAM_PSR          = 4'd11;
  localparam logic [3:0] FAM_BX           = 4'd12;
  localparam logic [3:0] FAM_FETCH        = 4'd13;
  localparam logic [3:0] FAM_SWI          = 4'd14;
  localparam logic [3:0] FAM_UNDEF        = 4'd15;

  // The FETCH microstate occupies the microcode slot of family 13, so the
  // decoder must never select that family
  localparam logic [6:0] FETCH_STATE = {FAM_FETCH, 3'b000};

  // Bit positions inside the {N,Z,C,V} flags vector
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // ARM condition codes as carried in ir[31:28]
  typedef enum logic [3:0] {
    COND_EQ = 4'h0,
    COND_NE = 4'h1,
    COND_CS = 4'h2,
    COND_CC = 4'h3,
    COND_MI = 4'h4,
    COND_PL = 4'h5,
    COND_VS = 4'h6,
    COND_VC = 4'h7,
    COND_HI = 4'h8,
    COND_LS = 4'h9,
    COND_GE = 4'hA,
    COND_LT = 4'hB,
    COND_GT = 4'hC,
    COND_LE = 4'hD,
    COND_AL = 4'hE,
    COND_NV = 4'hF
  } cond_e;

  // Fetch FSM: IDLE outside FETCH, WAIT while the IR is empty, HELD once valid
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HELD = 2'd2
  } fetch_state_e;

  // One-hot expansion of a family index
  function automatic logic [15:0] familyOneHot(input logic [3:0] idx);
    return 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/arm_cond_check.sv
// arm_cond_check
// Purely combinational ARM condition evaluator, shared by the instruction
// front end and the branch unit.
//   cond  [3:0] in  - condition field (ir[31:28])
//   flags [3:0] in  - {N,Z,C,V}
//   pass        out - 1 when the instruction should execute
// Code 1111 (NV) never passes.
module arm_cond_check
  import arm_decode_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  // Standard ARM condition table; NV is treated as "never" rather than the
  // legacy unpredictable encoding so skipped instructions are deterministic
  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = ~z;
      COND_CS: pass = c;
      COND_CC: pass = ~c;
      COND_MI: pass = n;
      COND_PL: pass = ~n;
      COND_VS: pass = v;
      COND_VC: pass = ~v;
      COND_HI: pass = c & ~z;
      COND_LS: pass = ~c | z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = ~z & (n == v);
      COND_LE: pass = z | (n != v);
      COND_AL: pass = 1'b1;
      COND_NV: pass = 1'b0;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_decode_unit.sv
// instr_decode_unit
// Front end of the microsequencer: fetches instruction words, holds them in
// the IR, keeps the NZCV flags and reports the one-hot family plus the COND
// qualifier while the sequencer sits in FETCH.
//   clk, reset        in  - clock, synchronous active-high reset
//   curr_state  [6:0] in  - current microstate from the microsequencer
//   mem_data   [31:0] in  - instruction word from memory
//   mem_ready         in  - mem_data valid this cycle (only looked at in WAIT)
//   ld_flags          in  - load alu_flags into the flags register
//   alu_flags   [3:0] in  - {N,Z,C,V} from the ALU
//   mem_req           out - instruction fetch request (WAIT only)
//   family_bits[15:0] out - one-hot family of the held IR (bit 13 never set)
//   COND              out - proceed qualifier (1 IDLE, 0 WAIT, cond pass HELD)
//   ir         [31:0] out - instruction register
//   flags       [3:0] out - {N,Z,C,V}
module instr_decode_unit #(
  parameter logic [6:0] FETCH_STATE = arm_decode_pkg::FETCH_STATE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  curr_state,
  input  logic [31:0] mem_data,
  input  logic        mem_ready,
  input  logic        ld_flags,
  input  logic [3:0]  alu_flags,
  output logic        mem_req,
  output logic [15:0] family_bits,
  output logic        COND,
  output logic [31:0] ir,
  output logic [3:0]  flags
);

  arm_decode_pkg::fetch_state_e stateQ;
  arm_decode_pkg::fetch_state_e stateD;

  logic [31:0] irQ;
  logic [3:0]  flagsQ;
  logic        inFetch;
  logic        irLoad;
  logic        condPass;
  logic [3:0]  familyIdx;

  assign inFetch = (curr_state == FETCH_STATE);

  // The IR only captures on the WAIT->HELD edge; a word arriving after the
  // sequencer has left FETCH belongs to a dropped request and is discarded
  assign irLoad = (stateQ == arm_decode_pkg::ST_WAIT) && inFetch && mem_ready;

  // Condition is always judged against the registered flags, so a flags
  // load in the evaluation cycle only affects the next instruction
  arm_cond_check u_cond_check (
    .cond  (irQ[31:28]),
    .flags (flagsQ),
    .pass  (condPass)
  );

  // State register of the fetch FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= arm_decode_pkg::ST_IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // Next-state logic: leaving FETCH always forces IDLE; in HELD a passing
  // condition means the sequencer moves on at this edge, a failing one
  // skips the instruction and starts a fresh fetch
  always_comb begin
    stateD = stateQ;
    if (!inFetch) begin
      stateD = arm_decode_pkg::ST_IDLE;
    end else begin
      unique case (stateQ)
        arm_decode_pkg::ST_IDLE: stateD = arm_decode_pkg::ST_WAIT;
        arm_decode_pkg::ST_WAIT: begin
          if (mem_ready) begin
            stateD = arm_decode_pkg::ST_HELD;
          end
        end
        arm_decode_pkg::ST_HELD: begin
          if (condPass) begin
            stateD = arm_decode_pkg::ST_IDLE;
          end else begin
            stateD = arm_decode_pkg::ST_WAIT;
          end
        end
        default: stateD = arm_decode_pkg::ST_IDLE;
      endcase
    end
  end

  // Moore outputs of the fetch FSM; COND is high in IDLE because microcode
  // outside FETCH branches on its own event condition, not on this qualifier
  always_comb begin
    mem_req = 1'b0;
    COND    = 1'b1;
    unique case (stateQ)
      arm_decode_pkg::ST_IDLE: begin
        mem_req = 1'b0;
        COND    = 1'b1;
      end
      arm_decode_pkg::ST_WAIT: begin
        mem_req = 1'b1;
        COND    = 1'b0;
      end
      arm_decode_pkg::ST_HELD: begin
        mem_req = 1'b0;
        COND    = condPass;
      end
      default: begin
        mem_req = 1'b0;
        COND    = 1'b1;
      end
    endcase
  end

  // Instruction register; cleared by reset so a held instruction is lost
  always_ff @(posedge clk) begin
    if (reset) begin
      irQ <= 32'h0000_0000;
    end else if (irLoad) begin
      irQ <= mem_data;
    end
  end

  // NZCV flags register
  always_ff @(posedge clk) begin
    if (reset) begin
      flagsQ <= 4'h0;
    end else if (ld_flags) begin
      flagsQ <= alu_flags;
    end
  end

  // Family decode, checked in priority order; the more specific encodings
  // that live inside the data-processing space (BX, PSR, multiplies, SWP,
  // halfword) must be tested before the generic data-processing rules.
  // Family 13 is never produced since that slot is the FETCH microstate.
  always_comb begin
    familyIdx = arm_decode_pkg::FAM_UNDEF;
    if (irQ[27:4] == 24'h12FFF1) begin
      familyIdx = arm_decode_pkg::FAM_BX;
    end else if ((irQ[27:23] == 5'b00010 && !irQ[20] && irQ[7:4] == 4'b0000) ||
                 (irQ[27:23] == 5'b00110 && irQ[21:20] == 2'b10)) begin
      familyIdx = arm_decode_pkg::FAM_PSR;
    end else if (irQ[27:22] == 6'b000000 && irQ[7:4] == 4'b1001) begin
      familyIdx = arm_decode_pkg::FAM_MUL;
    end else if (irQ[27:23] == 5'b00001 && irQ[7:4] == 4'b1001) begin
      familyIdx = arm_decode_pkg::FAM_MUL_LONG;
    end else if (irQ[27:23] == 5'b00010 && irQ[21:20] == 2'b00 &&
                 irQ[11:4] == 8'b0000_1001) begin
      familyIdx = arm_decode_pkg::FAM_SWP;
    end else if (irQ[27:25] == 3'b000 && irQ[7] && irQ[4]) begin
      familyIdx = arm_decode_pkg::FAM_HALFWORD;
    end else if (irQ[27:25] == 3'b000 && !irQ[4]) begin
      familyIdx = arm_decode_pkg::FAM_DP_IMM_SHIFT;
    end else if (irQ[27:25] == 3'b000 && !irQ[7] && irQ[4]) begin
      familyIdx = arm_decode_pkg::FAM_DP_REG_SHIFT;
    end else if (irQ[27:25] == 3'b001) begin
      familyIdx = arm_decode_pkg::FAM_DP_IMM;
    end else if (irQ[27:25] == 3'b010) begin
      familyIdx = arm_decode_pkg::FAM_LS_IMM;
    end else if (irQ[27:25] == 3'b011 && !irQ[4]) begin
      familyIdx = arm_decode_pkg::FAM_LS_REG;
    end else if (irQ[27:25] == 3'b100) begin
      familyIdx = arm_decode_pkg::FAM_BLOCK;
    end else if (irQ[27:25] == 3'b101) begin
      familyIdx = arm_decode_pkg::FAM_BRANCH;
    end else if (irQ[27:24] == 4'b1111) begin
      familyIdx = arm_decode_pkg::FAM_SWI;
    end
  end

  assign family_bits = arm_decode_pkg::familyOneHot(familyIdx);
  assign ir          = irQ;
  assign flags       = flagsQ;

endmodule

// File: tb/tb_instr_decode_unit.sv
// tb_instr_decode_unit
// Directed test of instr_decode_unit: reset values, fetch latency, family
// decode of representative words, condition evaluation, skipped
// instructions, same-cycle flag loads, reset while HELD and leaving FETCH
// with a request outstanding.
module tb_instr_decode_unit;

  localparam logic [6:0] FETCH = 7'd104;
  localparam logic [6:0] OTHER = 7'd5;

  logic        clk;
  logic        reset;
  logic [6:0]  currState;
  logic [31:0] memData;
  logic        memReady;
  logic        ldFlags;
  logic [3:0]  aluFlags;
  logic        memReq;
  logic [15:0] familyBits;
  logic        cond;
  logic [31:0] irOut;
  logic [3:0]  flagsOut;

  int assertCount = 0;
  int failCount   = 0;

  instr_decode_unit dut (
    .clk         (clk),
    .reset       (reset),
    .curr_state  (currState),
    .mem_data    (memData),
    .mem_ready   (memReady),
    .ld_flags    (ldFlags),
    .alu_flags   (aluFlags),
    .mem_req     (memReq),
    .family_bits (familyBits),
    .COND        (cond),
    .ir          (irOut),
    .flags       (flagsOut)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports every check
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [6:0] st, input logic rdy,
                               input logic [31:0] data);
    currState = st;
    memReady  = rdy;
    memData   = data;
  endtask

  // Load the flags while parked in WAIT with no data arriving
  task automatic loadFlags(input logic [3:0] value);
    ldFlags  = 1'b1;
    aluFlags = value;
    tick();
    ldFlags  = 1'b0;
    checkOutput("flags_load", {28'h0, flagsOut}, {28'h0, value});
  endtask

  // Starting in WAIT, hold off for waits cycles then deliver word; ends in HELD
  task automatic fetchInstr(input logic [31:0] word, input int waits);
    for (int i = 0; i < waits; i++) begin
      checkOutput("mem_req_wait", {31'h0, memReq}, 32'h1);
      applyStimulus(FETCH, 1'b0, 32'h0);
      tick();
    end
    checkOutput("mem_req_last", {31'h0, memReq}, 32'h1);
    applyStimulus(FETCH, 1'b1, word);
    tick();
    applyStimulus(FETCH, 1'b0, 32'h0);
    checkOutput("ir_loaded", irOut, word);
    checkOutput("mem_req_held", {31'h0, memReq}, 32'h0);
  endtask

  // Sequencer leaves FETCH for a cycle, then returns; ends in WAIT
  task automatic leaveAndReenter();
    applyStimulus(OTHER, 1'b0, 32'h0);
    tick();
    checkOutput("idle_cond", {31'h0, cond}, 32'h1);
    checkOutput("idle_mem_req", {31'h0, memReq}, 32'h0);
    applyStimulus(FETCH, 1'b0, 32'h0);
    tick();
    checkOutput("wait_mem_req", {31'h0, memReq}, 32'h1);
    checkOutput("wait_cond", {31'h0, cond}, 32'h0);
  endtask

  // Family decode vectors
  logic [31:0] famWord [3] = '{32'hE001_0392, 32'hE102_1093, 32'hE12F_FF1E};
  logic [15:0] famExp  [3] = '{16'h0008, 16'h0020, 16'h1000};

  // Condition table: flags {N,Z,C,V}, condition code, expected pass
  logic [3:0] ctFlags [16] = '{4'b0010, 4'b0110, 4'b1000, 4'b1001,
                               4'b1001, 4'b1101, 4'b0100, 4'b0001,
                               4'b0000, 4'b0010, 4'b1000, 4'b1000,
                               4'b0100, 4'b0010, 4'b1000, 4'b0000};
  logic [3:0] ctCode  [16] = '{4'h8, 4'h8, 4'hA, 4'hA, 4'hC, 4'hC, 4'hD, 4'h6,
                               4'h3, 4'h2, 4'h4, 4'h5, 4'h1, 4'h9, 4'hB, 4'h7};
  logic       ctExp   [16] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                               1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

  initial begin
    reset    = 1'b1;
    ldFlags  = 1'b0;
    aluFlags = 4'h0;
    applyStimulus(OTHER, 1'b0, 32'h0);
    tick();
    tick();

    // Reset state
    checkOutput("rst_ir", irOut, 32'h0);
    checkOutput("rst_family", {16'h0, familyBits}, 32'h0001);
    checkOutput("rst_flags", {28'h0, flagsOut}, 32'h0);
    checkOutput("rst_mem_req", {31'h0, memReq}, 32'h0);
    checkOutput("rst_cond", {31'h0, cond}, 32'h1);

    reset = 1'b0;
    applyStimulus(FETCH, 1'b0, 32'h0);
    tick();
    checkOutput("first_mem_req", {31'h0, memReq}, 32'h1);
    checkOutput("first_cond", {31'h0, cond}, 32'h0);

    // Immediate data processing after 3 wait cycles
    fetchInstr(32'hE3A0_1005, 3);
    checkOutput("dpimm_family", {16'h0, familyBits}, 32'h0004);
    checkOutput("dpimm_cond", {31'h0, cond}, 32'h1);
    leaveAndReenter();

    // BEQ not taken with Z=0: skipped, new request next cycle
    fetchInstr(32'h0A00_0002, 0);
    checkOutput("beq_nt_family", {16'h0, familyBits}, 32'h0400);
    checkOutput("beq_nt_cond", {31'h0, cond}, 32'h0);
    tick();
    checkOutput("beq_nt_refetch", {31'h0, memReq}, 32'h1);

    // BEQ taken with Z=1
    loadFlags(4'b0100);
    fetchInstr(32'h0A00_0002, 0);
    checkOutput("beq_t_family", {16'h0, familyBits}, 32'h0400);
    checkOutput("beq_t_cond", {31'h0, cond}, 32'h1);
    leaveAndReenter();

    // Multiply, swap, BX
    for (int i = 0; i < 3; i++) begin
      fetchInstr(famWord[i], 1);
      checkOutput("family", {16'h0, familyBits}, {16'h0, famExp[i]});
      checkOutput("bit13_clear", {31'h0, familyBits[13]}, 32'h0);
      checkOutput("family_cond", {31'h0, cond}, 32'h1);
      leaveAndReenter();
    end

    // NV never executes, then SWI
    fetchInstr(32'hF3A0_1005, 0);
    checkOutput("nv_cond", {31'h0, cond}, 32'h0);
    tick();
    checkOutput("nv_refetch", {31'h0, memReq}, 32'h1);
    fetchInstr(32'hEF00_0000, 0);
    checkOutput("swi_family", {16'h0, familyBits}, 32'h4000);
    checkOutput("swi_cond", {31'h0, cond}, 32'h1);
    leaveAndReenter();

    // Condition code table
    for (int i = 0; i < 16; i++) begin
      loadFlags(ctFlags[i]);
      fetchInstr({ctCode[i], 28'h3A0_1005}, 0);
      checkOutput("cond_table", {31'h0, cond}, {31'h0, ctExp[i]});
      leaveAndReenter();
    end

    // Flags loaded in the evaluation cycle: old flags decide
    loadFlags(4'b0000);
    fetchInstr(32'h0A00_0002, 0);
    ldFlags  = 1'b1;
    aluFlags = 4'b0100;
    #1;
    checkOutput("ldflags_old_cond", {31'h0, cond}, 32'h0);
    tick();
    ldFlags = 1'b0;
    checkOutput("ldflags_new", {28'h0, flagsOut}, 32'h4);
    checkOutput("ldflags_refetch", {31'h0, memReq}, 32'h1);

    // Synchronous reset while HELD
    fetchInstr(32'hE3A0_1005, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("hrst_ir", irOut, 32'h0);
    checkOutput("hrst_family", {16'h0, familyBits}, 32'h0001);
    checkOutput("hrst_mem_req", {31'h0, memReq}, 32'h0);
    checkOutput("hrst_cond", {31'h0, cond}, 32'h1);
    checkOutput("hrst_flags", {28'h0, flagsOut}, 32'h0);
    tick();
    checkOutput("hrst_refetch", {31'h0, memReq}, 32'h1);

    // Leaving FETCH while in WAIT drops the request and ignores the data
    applyStimulus(OTHER, 1'b1, 32'hEF00_0000);
    tick();
    applyStimulus(OTHER, 1'b0, 32'h0);
    checkOutput("early_mem_req", {31'h0, memReq}, 32'h0);
    checkOutput("early_ir", irOut, 32'h0);
    checkOutput("early_cond", {31'h0, cond}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
